// File: rtl/rob_tagged_regfile_pkg.sv
// Shared sizing for the ROB-tagged architectural register file.
// Also holds the tag value the core treats as "no producer".
package rob_tagged_regfile_pkg;

    localparam int RF_REG_CNT = 32;
    localparam int RF_DATA_W  = 32;
    localparam int RF_TAG_W   = 3;
    localparam int RF_NAME_W  = $clog2(RF_REG_CNT);

    // Tag reported for registers that have no pending producer.
    localparam logic [RF_TAG_W-1:0] NO_LOCK_TAG = {RF_TAG_W{1'b0}};

endpackage

// File: rtl/rob_tagged_regfile_read_port.sv
// One decoder read port: table entry plus same-cycle commit bypass.
// The highest-index commit port with a name and tag match supplies the data.
module regfile_read_port
    import rob_tagged_regfile_pkg::*;
#(
    parameter int NAME_W   = RF_NAME_W,
    parameter int TAG_W    = RF_TAG_W,
    parameter int DATA_W   = RF_DATA_W,
    parameter int CM_PORTS = 2
) (
    input  logic                       rd_en,
    input  logic [NAME_W-1:0]          rd_name,
    input  logic                       ent_locked,
    input  logic [TAG_W-1:0]           ent_tag,
    input  logic [DATA_W-1:0]          ent_data,
    input  logic [CM_PORTS-1:0]        cm_we,
    input  logic [CM_PORTS*NAME_W-1:0] cm_name,
    input  logic [CM_PORTS*DATA_W-1:0] cm_data,
    input  logic [CM_PORTS*TAG_W-1:0]  cm_tag,
    output logic                       locked,
    output logic [TAG_W-1:0]           tag,
    output logic [DATA_W-1:0]          data
);

    logic              byp_hit_s;
    logic [DATA_W-1:0] byp_data_s;
    logic              match_s [CM_PORTS];

    // Scan commit ports in ascending order so the youngest matching commit wins.
    always_comb begin
        byp_hit_s  = 1'b0;
        byp_data_s = {DATA_W{1'b0}};
        for (int k = 0; k < CM_PORTS; k++) begin
            match_s[k] = cm_we[k]
                      && (cm_name[k*NAME_W +: NAME_W] == rd_name)
                      && (cm_tag[k*TAG_W +: TAG_W] == ent_tag);
            byp_hit_s  = byp_hit_s | match_s[k];
            byp_data_s = match_s[k] ? cm_data[k*DATA_W +: DATA_W] : byp_data_s;
        end
    end

    // Port outputs: disabled, bypassed, or plain table contents.
    always_comb begin
        locked = 1'b0;
        tag    = TAG_W'(NO_LOCK_TAG);
        data   = {DATA_W{1'b0}};
        if (!rd_en) begin
            locked = 1'b0;
            tag    = TAG_W'(NO_LOCK_TAG);
            data   = {DATA_W{1'b0}};
        end else if (ent_locked && byp_hit_s) begin
            locked = 1'b0;
            tag    = ent_tag;
            data   = byp_data_s;
        end else begin
            locked = ent_locked;
            tag    = ent_tag;
            data   = ent_data;
        end
    end

endmodule

// File: rtl/rob_tagged_regfile.sv
// Architectural register file with per-register ROB rename tags.
// In-order multi-port commit, destination allocation and mispredict flush.
module rob_tagged_regfile
    import rob_tagged_regfile_pkg::*;
#(
    parameter int REG_CNT  = RF_REG_CNT,
    parameter int DATA_W   = RF_DATA_W,
    parameter int TAG_W    = RF_TAG_W,
    parameter int RD_PORTS = 2,
    parameter int CM_PORTS = 2,
    localparam int NAME_W  = $clog2(REG_CNT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CM_PORTS-1:0]        cm_we,
    input  logic [CM_PORTS*NAME_W-1:0] cm_name,
    input  logic [CM_PORTS*DATA_W-1:0] cm_data,
    input  logic [CM_PORTS*TAG_W-1:0]  cm_tag,
    input  logic [RD_PORTS-1:0]        rd_en,
    input  logic [RD_PORTS*NAME_W-1:0] rd_name,
    output logic [RD_PORTS-1:0]        rd_locked,
    output logic [RD_PORTS*TAG_W-1:0]  rd_tag,
    output logic [RD_PORTS*DATA_W-1:0] rd_data,
    input  logic                       alloc_we,
    input  logic [NAME_W-1:0]          alloc_name,
    input  logic [TAG_W-1:0]           alloc_tag,
    input  logic                       flush
);

    logic [DATA_W-1:0] data_r     [REG_CNT];
    logic              lock_r     [REG_CNT];
    logic [TAG_W-1:0]  tag_r      [REG_CNT];

    logic [DATA_W-1:0] wr_data_s  [REG_CNT];
    logic              clr_hit_s  [REG_CNT];
    logic [DATA_W-1:0] data_nxt_s [REG_CNT];
    logic              lock_nxt_s [REG_CNT];
    logic [TAG_W-1:0]  tag_nxt_s  [REG_CNT];

    // Commit effects per register; lock match uses the pre-commit tag so either port may clear.
    always_comb begin
        for (int i = 0; i < REG_CNT; i++) begin
            wr_data_s[i] = data_r[i];
            clr_hit_s[i] = 1'b0;
            for (int k = 0; k < CM_PORTS; k++) begin
                if (cm_we[k] && (cm_name[k*NAME_W +: NAME_W] == NAME_W'(i))) begin
                    wr_data_s[i] = cm_data[k*DATA_W +: DATA_W];
                    clr_hit_s[i] = clr_hit_s[i]
                                 | (lock_r[i] && (tag_r[i] == cm_tag[k*TAG_W +: TAG_W]));
                end else begin
                    wr_data_s[i] = wr_data_s[i];
                    clr_hit_s[i] = clr_hit_s[i];
                end
            end
        end
    end

    // Next table state: flush beats allocation, allocation beats a commit clear.
    always_comb begin
        for (int i = 0; i < REG_CNT; i++) begin
            data_nxt_s[i] = data_r[i];
            lock_nxt_s[i] = lock_r[i];
            tag_nxt_s[i]  = tag_r[i];
            if (i == 0) begin
                data_nxt_s[i] = {DATA_W{1'b0}};
                lock_nxt_s[i] = 1'b0;
                tag_nxt_s[i]  = TAG_W'(NO_LOCK_TAG);
            end else if (flush) begin
                data_nxt_s[i] = wr_data_s[i];
                lock_nxt_s[i] = 1'b0;
                tag_nxt_s[i]  = tag_r[i];
            end else if (alloc_we && (alloc_name == NAME_W'(i))) begin
                data_nxt_s[i] = wr_data_s[i];
                lock_nxt_s[i] = 1'b1;
                tag_nxt_s[i]  = alloc_tag;
            end else begin
                data_nxt_s[i] = wr_data_s[i];
                lock_nxt_s[i] = lock_r[i] & ~clr_hit_s[i];
                tag_nxt_s[i]  = tag_r[i];
            end
        end
    end

    // Table registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                data_r[i] <= {DATA_W{1'b0}};
                lock_r[i] <= 1'b0;
                tag_r[i]  <= {TAG_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < REG_CNT; i++) begin
                data_r[i] <= data_nxt_s[i];
                lock_r[i] <= lock_nxt_s[i];
                tag_r[i]  <= tag_nxt_s[i];
            end
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        regfile_read_port #(
            .NAME_W   (NAME_W),
            .TAG_W    (TAG_W),
            .DATA_W   (DATA_W),
            .CM_PORTS (CM_PORTS)
        ) u_port (
            .rd_en      (rd_en[p]),
            .rd_name    (rd_name[p*NAME_W +: NAME_W]),
            .ent_locked (lock_r[rd_name[p*NAME_W +: NAME_W]]),
            .ent_tag    (tag_r[rd_name[p*NAME_W +: NAME_W]]),
            .ent_data   (data_r[rd_name[p*NAME_W +: NAME_W]]),
            .cm_we      (cm_we),
            .cm_name    (cm_name),
            .cm_data    (cm_data),
            .cm_tag     (cm_tag),
            .locked     (rd_locked[p]),
            .tag        (rd_tag[p*TAG_W +: TAG_W]),
            .data       (rd_data[p*DATA_W +: DATA_W])
        );
    end

endmodule

// File: doc/rob_tagged_regfile.md
Name: rob_tagged_regfile

Overview:
- Architectural register file with per-register ROB rename tags for the Tomasulo core.
- Successor to the single-commit, two-read register file. Adds parametrised read-port count, parametrised commit width, and a whole-table flush on branch mispredict.
- Sits between the decoder (operand reads, destination tag allocation) and the ROB (in-order commit).

Parameters:
REG_CNT, 32, number of architectural registers; register 0 is hardwired to zero
DATA_W, 32, register data width
TAG_W, 3, ROB entry index width
RD_PORTS, 2, number of decoder read ports
CM_PORTS, 2, commits per cycle from the ROB; port 0 is the older commit

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cm_we  in  CM_PORTS  per-port commit valid
cm_name  in  CM_PORTS*$clog2(REG_CNT)  committing destination registers, port k at slice k
cm_data  in  CM_PORTS*DATA_W  commit data
cm_tag  in  CM_PORTS*TAG_W  ROB entry being committed
rd_en  in  RD_PORTS  per-port read enable
rd_name  in  RD_PORTS*$clog2(REG_CNT)  source registers
rd_locked  out  RD_PORTS  1 = value pending in the ROB
rd_tag  out  RD_PORTS*TAG_W  ROB entry producing the value; valid only when locked
rd_data  out  RD_PORTS*DATA_W  register value; valid only when unlocked
alloc_we  in  1  decoder claims a destination
alloc_name  in  $clog2(REG_CNT)  destination register
alloc_tag  in  TAG_W  allocated ROB entry
flush  in  1  mispredict recovery; drops every lock

Behaviour:
- State per register: data[DATA_W], locked bit, tag[TAG_W]. Register 0 is never written and never locked; writes and allocations to register 0 are ignored.
- Reset (rst high at a clk edge): all data = 0, all locked = 0, all tags = 0. rst has priority over every other input. An allocation or commit in the reset cycle is lost.
- Reads are combinational with zero latency.
  - rd_en = 0 gives locked = 0, tag = 0, data = 0.
  - Otherwise the port returns the table entry, with a commit bypass: if the register is locked and a valid commit in the same cycle names the same register with cm_tag equal to the stored tag, the port returns locked = 0 and data = cm_data.
  - A bypass that matches on name but not on tag (an older producer) leaves the port locked with the stored tag.
  - When two commit ports match, the higher port index wins the bypass.
  - Reads never bypass a same-cycle allocation; the decoder forwards its own destination.
- Commit at the clk edge, port k with cm_we[k] and cm_name[k] != 0:
  - data[name] <= cm_data[k], unconditionally; data always tracks in-order commit.
  - The lock is cleared only if the entry is locked, tag == cm_tag[k], and no same-cycle allocation targets the same register.
- Two commits to the same register in one cycle: the higher port index writes the data. The lock clears if either tag matches, subject to the allocation rule.
- Allocation at the clk edge, alloc_we with alloc_name != 0: locked <= 1, tag <= alloc_tag. Allocation overrides any commit-driven clear on the same register.
- Flush at the clk edge: every locked bit <= 0.
  - Commits in the flush cycle still write data.
  - An allocation in the flush cycle is discarded.
  - flush is lower priority than rst only.
- No handshake stalls: the block accepts every request every cycle. Checking ROB tag uniqueness is the ROB's job.
- Tags are opaque. No wrap-around arithmetic is done on them; equality compare only.

Decomposition:
- Shared package (defines header): REG_CNT, DATA_W, TAG_W, the register-name width derived from REG_CNT, and the "no lock" encoding used elsewhere in the core.
- One natural sub-module, regfile_read_port: the combinational read with commit-bypass priority, instantiated RD_PORTS times by a generate loop.
- The table, commit, allocation and flush logic stay in the top module.

Test Plan:
1. Reset: assert rst for 1 cycle, then read r5 on both ports -> locked = 0, data = 0. Commit r0 = 0xFFFF -> a read of r0 returns 0.
2. Alloc r3 with tag 4. Next cycle read r3 -> locked = 1, tag = 4. Commit r3 data 0xABCD tag 4 in the same cycle as the read -> that read gives locked = 0, data = 0xABCD. Following cycle, table read gives the same result.
3. Alloc r3 tag 2, later alloc r3 tag 5, then commit r3 tag 2 data 0x11 -> r3 data = 0x11 but still locked with tag 5. Commit tag 5 data 0x22 -> unlocked, data 0x22.
4. Same cycle: commit r7 tag 1 (r7 locked with tag 1) and alloc r7 tag 6 -> r7 data updated, locked with tag 6.
5. Dual commit: port 0 r9 tag 0 data 0xA, port 1 r9 tag 1 data 0xB, r9 locked with tag 1 -> data 0xB, unlocked. A same-cycle read returns 0xB.
6. Lock r1, r2, r4. Assert flush together with alloc r6 tag 3 and commit r2 data 0x5 -> all registers unlocked, r6 unlocked, r2 data 0x5.
